my_rom_top_module: RTL and testbench
====================================

MY_ROM_TOP_MODULE -- requirements
Module: my_rom_top_module

Interface
REQ-001 Parameter: DATA_W, default 4, width of each ROM word and of Data.
REQ-002 Parameter: DEPTH, default 16, number of ROM words; fixed power of two.
REQ-003 Parameter: ADDR_W, default 4, address counter width; SHALL equal log2(DEPTH).
REQ-004 Port: Clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port: Rst  input  1  reset, synchronous and active-high.
REQ-006 Port: Data  output  DATA_W  current ROM word.

Function
REQ-007 The block SHALL be a free-running sequencer: an internal ADDR_W-bit address counter indexes a read-only table, and the selected word drives Data.
REQ-008 ROM contents, address 0..15, SHALL be: 0x1,0x3,0x5,0x7,0x9,0xB,0xD,0xF,0xE,0xC,0xA,0x8,0x6,0x4,0x2,0x0.
REQ-009 On each rising Clk edge with Rst=0, the address SHALL advance by 1 modulo DEPTH.
REQ-010 Wrap-around: address 15 SHALL be followed by address 0 with no idle cycle or gap.
REQ-011 Default build (no macro): Data SHALL be a combinational decode of the registered address, i.e. Data = ROM[addr] in the same cycle.
REQ-012 Default build: after the k-th rising edge following reset release, Data SHALL equal ROM[k mod 16].
REQ-013 Content is constant; no write path, no enable, and no other inputs SHALL exist.
REQ-014 Data SHALL never be X/Z after the first reset edge.

Reset
REQ-015 A rising edge with Rst=1 SHALL load address 0; default build Data therefore SHALL read 0x1 (ROM[0]) in that cycle.
REQ-016 Rst asserted mid-sequence SHALL take effect at the next edge and restart from address 0; Rst held high SHALL keep the address at 0.
REQ-017 Before the first reset edge, state is undefined; no asynchronous reset path SHALL exist.

Configuration
REQ-018 Macro MYROM_OUTREG_EN, when defined, SHALL insert an output register: each non-reset edge loads ROM[addr] into Data, adding exactly one cycle of latency.
REQ-019 With MYROM_OUTREG_EN, a reset edge SHALL clear the output register to 0x0, and after the k-th edge following release Data SHALL equal ROM[(k-1) mod 16].
REQ-020 Without MYROM_OUTREG_EN, REQ-011/REQ-012/REQ-015 SHALL apply and no output register SHALL be inferred.

Structure
REQ-021 Package myrom_pkg SHALL hold DATA_W, DEPTH, ADDR_W defaults and the ROM content table constant.
REQ-022 One sub-module, my_rom, SHALL implement the pure combinational table lookup (addr in, word out); the counter and optional output register live in the top module.

Verification
REQ-023 Rst=1 for one edge, then released -> default build: Data=0x1 at reset, then 0x3, 0x5, 0x7 on the next three edges.
REQ-024 Run 17 edges after release -> Data after edge 15 = 0x0, after edge 16 = 0x1 (wrap), after edge 17 = 0x3.
REQ-025 Reset reasserted after edge 6 (Data=0xD) -> next edge Data=0x1; release -> following edge Data=0x3.
REQ-026 Rst held high for 5 edges -> Data stays 0x1 throughout; first edge after release gives 0x3.
REQ-027 MYROM_OUTREG_EN build, same stimulus as REQ-023 -> Data=0x0 at reset, then 0x1, 0x3, 0x5 on the next three edges.
REQ-028 Full 25-edge run in both builds -> no X on Data after first reset edge; sequence matches REQ-008 table cyclically.

Source files
------------

// File: rtl/myrom_pkg.sv
// Shared defaults and ROM contents for the my_rom sequencer.
// Contents form an up-odd / down-even 4-bit ramp.
package myrom_pkg;

   localparam int DATA_W_DEF = 4;
   localparam int DEPTH_DEF  = 16;
   localparam int ADDR_W_DEF = 4;

   localparam logic [DATA_W_DEF-1:0] ROM_TABLE [DEPTH_DEF] = '{
      4'h1, 4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hD, 4'hF,
      4'hE, 4'hC, 4'hA, 4'h8, 4'h6, 4'h4, 4'h2, 4'h0
   };

endpackage

// File: rtl/my_rom.sv
// Pure combinational lookup into the constant ROM table.
// Addresses beyond the table read as zero.
module my_rom
   import myrom_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] word
);

   // select the table entry matching addr
   always_comb begin
      word = '0;
      for (int i = 0; i < DEPTH && i < DEPTH_DEF; i++) begin
         if (addr == ADDR_W'(i)) word = DATA_W'(ROM_TABLE[i]);
      end
   end

endmodule

// File: rtl/my_rom_top_module.sv
// Free-running ROM sequencer: wrapping address counter feeding my_rom.
// Define MYROM_OUTREG_EN to register Data (one extra cycle latency).
module my_rom_top_module
   import myrom_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              Clk,
   input  logic              Rst,
   output logic [DATA_W-1:0] Data
);

   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] rom_word;

   // next address: increment, natural wrap at DEPTH (power of two)
   always_comb begin
      addr_d = addr_q + ADDR_W'(1);
   end

   // address counter, synchronous reset to entry 0
   always_ff @(posedge Clk) begin
      if (Rst) addr_q <= '0;
      else     addr_q <= addr_d;
   end

   my_rom #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_rom (
      .addr (addr_q),
      .word (rom_word)
   );

`ifdef MYROM_OUTREG_EN
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_d;

   // output register captures the word for the current address
   always_comb begin
      data_d = rom_word;
   end

   // output register, cleared on reset
   always_ff @(posedge Clk) begin
      if (Rst) data_q <= '0;
      else     data_q <= data_d;
   end

   assign Data = data_q;
`else
   assign Data = rom_word;
`endif

endmodule

// File: tb/tb_my_rom_top_module.sv
// Scoreboard bench for my_rom_top_module.
// Honours MYROM_OUTREG_EN to select the expected latency.
module tb_my_rom_top_module;

   logic       Clk;
   logic       Rst;
   logic [3:0] Data;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] tbl [16];
   logic [3:0] m_addr;
   logic [3:0] m_out;
   logic [3:0] exp_q [$];

   my_rom_top_module dut (
      .Clk  (Clk),
      .Rst  (Rst),
      .Data (Data)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic check(input string tag, input logic [3:0] got,
                        input logic [3:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // drive Rst for one edge, predict, then compare after the edge
   task automatic tick(input logic rst, input string tag);
      logic [3:0] e;
      @(negedge Clk);
      Rst = rst;
      if (rst) begin
         m_addr = 4'h0;
         m_out  = 4'h0;
      end else begin
         m_out  = tbl[m_addr];
         m_addr = m_addr + 4'h1;
      end
`ifdef MYROM_OUTREG_EN
      exp_q.push_back(m_out);
`else
      exp_q.push_back(tbl[m_addr]);
`endif
      @(posedge Clk);
      #1;
      if (exp_q.size() == 0) begin
         check({tag, "_empty"}, 4'hX, 4'h0);
      end else begin
         e = exp_q.pop_front();
         check(tag, Data, e);
      end
   endtask

   initial begin
      tbl = '{4'h1, 4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hD, 4'hF,
              4'hE, 4'hC, 4'hA, 4'h8, 4'h6, 4'h4, 4'h2, 4'h0};
      m_addr = 4'h0;
      m_out  = 4'h0;
      Rst    = 1'b1;

      // single reset edge, then run through one full wrap and beyond
      tick(1'b1, "rst1");
`ifdef MYROM_OUTREG_EN
      check("rst1_val", Data, 4'h0);
`else
      check("rst1_val", Data, 4'h1);
`endif
      for (int i = 1; i <= 17; i++) tick(1'b0, $sformatf("run_e%0d", i));
`ifndef MYROM_OUTREG_EN
      check("wrap_e17", Data, 4'h3);
`else
      check("wrap_e17", Data, 4'h1);
`endif

      // mid-sequence reset after six edges
      tick(1'b1, "rst2");
      for (int i = 1; i <= 6; i++) tick(1'b0, $sformatf("mid_e%0d", i));
      tick(1'b1, "rst_mid");
      tick(1'b0, "rel_mid");

      // reset held for five edges
      for (int i = 1; i <= 5; i++) tick(1'b1, $sformatf("hold_e%0d", i));
      tick(1'b0, "rel_hold");

      // long run across multiple wraps
      tick(1'b1, "rst3");
      for (int i = 1; i <= 25; i++) tick(1'b0, $sformatf("long_e%0d", i));

      check("sb_drained", 4'(exp_q.size()), 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
